op_encoder_fifo: RTL
====================

// Module: op_encoder_fifo
// PURPOSE
// - Parametrised opcode encoder for the mini-processor control path.
// - Converts a CTRL_W-bit control word to an OP_W-bit opcode. The encoding is
//   chosen per request: pass-through, highest-bit priority or lowest-bit priority.
// - Encoded opcodes are buffered in a DEPTH-entry FIFO. Input and output each
//   use a valid/ready handshake, so the control source and the decode stage can
//   stall independently.
// PARAMETERS
// - CTRL_W   4               width of the control word
// - OP_W     $clog2(CTRL_W)  opcode width, >=1
// - DEPTH    4               FIFO entries, power of two, >=2
// PORTS
// - clk        in   1             single clock, rising edge
// - rst_n      in   1             asynchronous active-low reset
// - in_valid   in   1             ctrl/mode are valid
// - in_ready   out  1             FIFO can accept a request (= !full)
// - ctrl       in   CTRL_W        control word
// - mode       in   2             00 pass, 01 prio-high, 10 prio-low, 11 reserved
// - out_valid  out  1             FIFO head is valid (= !empty)
// - out_ready  in   1             consumer takes the head
// - op_code    out  OP_W          encoded opcode at FIFO head
// - op_none    out  1             head came from a priority mode with ctrl==0
// - count      out  $clog2(DEPTH)+1  current occupancy
// - err        out  1             one-cycle pulse: reserved mode accepted
// BEHAVIOUR
// - Push = in_valid & in_ready. Pop = out_valid & out_ready.
// - Encoding is combinational at push time; mode and ctrl are sampled at the push edge.
// - Mode 00: op_code = ctrl[OP_W-1:0], op_none = 0.
// - Mode 01: op_code = index of the highest set bit.
// - Mode 10: op_code = index of the lowest set bit.
// - Modes 01/10 with ctrl==0: op_code = 0, op_none = 1. The entry is still enqueued.
// - Mode 11: encoded as mode 00. err is high for exactly the cycle after the push edge.
// - Each entry stores {op_none, op_code}. The head is shown ahead: op_code/op_none
//   reflect the head entry whenever out_valid=1, and are held at 0 when the FIFO is empty.
// - Latency: a push into an empty FIFO gives out_valid=1 after one clock edge.
//   There is no combinational in->out path.
// - Full (count==DEPTH): in_ready=0 and in_valid is ignored, even if a pop happens
//   in the same cycle. in_ready rises on the cycle after the pop.
// - Empty: out_valid=0 and out_ready is ignored; count never underflows.
// - Simultaneous push and pop when not full and not empty: count is unchanged and
//   FIFO order is preserved.
// - Pointers are log2(DEPTH) bits and wrap naturally; count tracks occupancy.
// - Reset (asynchronous, mid-operation included): all contents are discarded.
//   Values while rst_n=0: wr/rd pointers=0, count=0, out_valid=0, in_ready=0,
//   op_code=0, op_none=0, err=0.
// - in_ready goes to 1 on the first clock edge after rst_n deasserts.
// STRUCTURE
// - Package op_enc_pkg holds:
//   - localparams MODE_PASS=2'b00, MODE_PRIO_HI=2'b01, MODE_PRIO_LO=2'b10, MODE_RSVD=2'b11;
//   - function prio_enc(ctrl, dir), which returns {none, idx}.
// - Sub-module op_enc_sync_fifo (params W=OP_W+1, DEPTH) provides storage,
//   pointers, count, full and empty.
// - The top level holds the mode decode, the encoder and the err flop.
// TESTING
// - All tests use CTRL_W=4, OP_W=2, DEPTH=4.
// - T1 pass-through: mode=00, ctrl=4'b0110 pushed into an empty FIFO
//   -> next cycle out_valid=1, op_code=2'b10, op_none=0, count=1.
// - T2 priority: ctrl=4'b0110 with mode=01 -> op_code=2; with mode=10 -> op_code=1;
//   ctrl=4'b0000 with mode=01 -> op_code=0, op_none=1.
// - T3 full: out_ready=0, push ctrl=0,1,2,3 in mode 00 -> count=4, in_ready=0.
//   A 5th push is held. Then out_ready=1 -> op_code pops 0,1,2,3 in order,
//   and the 5th request is accepted once in_ready=1.
// - T4 simultaneous push and pop at count=2, sustained over 8 cycles
//   -> count stays 2, output order matches input order, no drops or duplicates.
// - T5 reset: drive rst_n=0 between clock edges while count=3
//   -> out_valid=0, count=0, op_code=0 immediately, with no clock edge needed.
//   After release, the first push appears one cycle later.
// - T6 reserved mode: mode=11, ctrl=4'b1011 -> err=1 for exactly one cycle,
//   op_code=2'b11 at the head.

Source files
------------

// File: rtl/op_enc_pkg.sv
// op_enc_pkg: request mode encodings and the shared priority encoder for the opcode path.
package op_enc_pkg;
    localparam logic [1:0] MODE_PASS    = 2'b00;
    localparam logic [1:0] MODE_PRIO_HI = 2'b01;
    localparam logic [1:0] MODE_PRIO_LO = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;
    localparam int MAX_W = 32;
    localparam int IDX_W = $clog2(MAX_W);

    typedef struct packed {
        logic             none;
        logic [IDX_W-1:0] idx;
    } prio_t;

    // dir=1 picks the highest set bit, dir=0 the lowest; scanning toward the preferred end lets the last hit win
    function automatic prio_t prio_enc(input logic [MAX_W-1:0] ctrl, input logic dir);
        prio_t r;
        r.none = (ctrl == '0);
        r.idx  = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (dir ? ctrl[i] : ctrl[MAX_W-1-i])
                r.idx = dir ? IDX_W'(i) : IDX_W'(MAX_W-1-i);
        end
        return r;
    endfunction
endpackage

// File: rtl/op_enc_sync_fifo.sv
// op_enc_sync_fifo: single-clock FIFO with show-ahead head, zeroed when empty.
module op_enc_sync_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !rd_en) count <= count + CW'(1);
            else if (rd_en && !wr_en) count <= count - CW'(1);
        end
    end

    // storage needs no reset: the pointers and count alone define what is valid
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/op_encoder_fifo.sv
// op_encoder_fifo: encodes control words into opcodes per request mode and buffers them
// in a valid/ready FIFO so producer and decode stage can stall independently.
module op_encoder_fifo #(
    parameter int CTRL_W = 4,
    parameter int OP_W   = $clog2(CTRL_W),
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        ctrl,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OP_W-1:0]          op_code,
    output logic                     op_none,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    import op_enc_pkg::*;

    logic            push, pop, full, empty, rdy, is_prio;
    prio_t           pe;
    logic [OP_W:0]   enc, head;

    always_comb begin
        is_prio = (mode == MODE_PRIO_HI) | (mode == MODE_PRIO_LO);
        pe      = prio_enc(MAX_W'(ctrl), mode == MODE_PRIO_HI);
        enc     = is_prio ? {pe.none, OP_W'(pe.idx)} : {1'b0, ctrl[OP_W-1:0]};
    end

    assign in_ready  = rdy & ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign {op_none, op_code} = head;

    // rdy holds in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy <= 1'b0;
            err <= 1'b0;
        end else begin
            rdy <= 1'b1;
            err <= push & (mode == MODE_RSVD);
        end
    end

    op_enc_sync_fifo #(.W(OP_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (enc),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
endmodule
